command_decoder: RTL and testbench
==================================

COMMAND_DECODER -- requirements
Module: command_decoder

Interface
REQ-001 SHALL have parameter ADDR_W, default 20, framebuffer word-address width.
REQ-002 SHALL have port commandClk  input  1  sole clock, rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port commandToGpu  input  16  command word from the host interface; 0 = no command; [15:12] opcode.
REQ-005 SHALL have port dataToGpu  input  16  operand paired with commandToGpu, valid in the same cycle.
REQ-006 SHALL have port dataFromGpu  output  16  read/status word returned to the host interface.
REQ-007 SHALL have port memAddr  output  ADDR_W  framebuffer word address.
REQ-008 SHALL have port memWrData  output  16  framebuffer write data.
REQ-009 SHALL have port memWrEn  output  1  write request.
REQ-010 SHALL have port memRdEn  output  1  read request.
REQ-011 SHALL have port memReady  input  1  framebuffer accepts the current request this cycle.
REQ-012 SHALL have port memRdData  input  16  read return data.
REQ-013 SHALL have port memRdValid  input  1  memRdData valid this cycle.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-015 SHALL have port errorFlag  output  1  sticky error.

Function
REQ-016 SHALL decode a command in any cycle where commandToGpu != 0; the upstream stage delivers at most one command per two cycles.
REQ-017 SHALL implement opcode 0x1 SET_ADDR_LO: addr[15:0] <= dataToGpu, one cycle, stays IDLE.
REQ-018 SHALL implement opcode 0x2 SET_ADDR_HI: addr[ADDR_W-1:16] <= dataToGpu[ADDR_W-17:0].
REQ-019 SHALL implement opcode 0x3 WRITE: enter WRITE; hold memWrEn=1, memAddr=addr, memWrData=dataToGpu until a cycle with memReady=1; then addr <= addr+1; return to IDLE.
REQ-020 SHALL implement opcode 0x4 READ: enter READ_REQ; hold memRdEn=1 until memReady=1; addr <= addr+1; go to READ_WAIT; on memRdValid=1 latch dataFromGpu <= memRdData; return to IDLE.
REQ-021 SHALL implement opcode 0x7 STATUS: dataFromGpu <= {busy, errorFlag, 14'd0} next cycle.
REQ-022 SHALL implement opcode 0xF CLEAR_ERR: errorFlag <= 0.
REQ-023 SHALL treat every other opcode as illegal: no state change except errorFlag <= 1.
REQ-024 SHALL drop a command arriving while busy=1 and set errorFlag (overrun).
REQ-025 SHALL wrap addr from 2^ADDR_W-1 to 0 on increment, with no error.
REQ-026 SHALL never assert memWrEn and memRdEn in the same cycle.
REQ-027 SHALL drive memWrEn/memRdEn and memAddr from registers; a request rises no earlier than the cycle after decode.
REQ-028 SHALL hold dataFromGpu until the next READ completion or STATUS.

Reset
REQ-029 SHALL on reset assertion immediately set state IDLE and addr, fillColor, fillCount, dataFromGpu, memAddr, memWrData to 0, and memWrEn, memRdEn, busy, errorFlag to 0.
REQ-030 SHALL abandon any in-flight request on reset; a memRdValid arriving after reset release in IDLE SHALL be ignored.

Configuration
REQ-031 SHALL, when macro CMD_FILL_EN is defined, implement opcode 0x5 SET_FILL (fillColor <= dataToGpu) and opcode 0x6 FILL.
REQ-032 SHALL implement FILL as follows: fillCount <= dataToGpu; count 0 is a no-op; otherwise in state FILL write fillColor at addr on each memReady=1, incrementing addr and decrementing fillCount, and return to IDLE after the last accept.
REQ-033 SHALL, when CMD_FILL_EN is undefined, omit fillColor, fillCount and FILL-state logic, and treat opcodes 0x5 and 0x6 as illegal per REQ-023.

Verification
REQ-034 SHALL cover: SET_ADDR_LO 0x1234, SET_ADDR_HI 0x0005, WRITE 0xBEEF with memReady low 3 cycles -> one write accepted at 0x51234 with data 0xBEEF; addr becomes 0x51235.
REQ-035 SHALL cover: addr=0xFFFFF, READ, memRdData=0xA5A5 two cycles after accept -> dataFromGpu=0xA5A5; addr=0x00000; busy low afterwards.
REQ-036 SHALL cover: WRITE issued while memReady=0, then a second WRITE two cycles later -> second command dropped, errorFlag=1; CLEAR_ERR -> errorFlag=0.
REQ-037 SHALL cover: with CMD_FILL_EN, SET_FILL 0x07E0 then FILL count 4 from addr 0x100 -> writes at 0x100..0x103, addr=0x104; FILL count 0 -> no write. Without CMD_FILL_EN, opcode 0x6 -> errorFlag=1 and no write.
REQ-038 SHALL cover: reset asserted mid-READ_WAIT -> memRdEn=0, busy=0 and addr=0 immediately; a late memRdValid leaves dataFromGpu=0.

Source files
------------

// File: rtl/command_decoder.sv
// Host command decoder: turns opcode/operand pairs into framebuffer read/write requests.
// Optional FILL support (SET_FILL / FILL opcodes) is enabled by defining CMD_FILL_EN.
`timescale 1ns/1ps

module command_decoder #(
    parameter int ADDR_W = 20
) (
    input  logic              commandClk,
    input  logic              reset,
    input  logic [15:0]       commandToGpu,
    input  logic [15:0]       dataToGpu,
    output logic [15:0]       dataFromGpu,
    output logic [ADDR_W-1:0] memAddr,
    output logic [15:0]       memWrData,
    output logic              memWrEn,
    output logic              memRdEn,
    input  logic              memReady,
    input  logic [15:0]       memRdData,
    input  logic              memRdValid,
    output logic              busy,
    output logic              errorFlag
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WRITE     = 3'd1;
    localparam logic [2:0] ST_READ_REQ  = 3'd2;
    localparam logic [2:0] ST_READ_WAIT = 3'd3;
`ifdef CMD_FILL_EN
    localparam logic [2:0] ST_FILL      = 3'd4;
`endif

    localparam logic [3:0] OP_SET_ADDR_LO = 4'h1;
    localparam logic [3:0] OP_SET_ADDR_HI = 4'h2;
    localparam logic [3:0] OP_WRITE       = 4'h3;
    localparam logic [3:0] OP_READ        = 4'h4;
`ifdef CMD_FILL_EN
    localparam logic [3:0] OP_SET_FILL    = 4'h5;
    localparam logic [3:0] OP_FILL        = 4'h6;
`endif
    localparam logic [3:0] OP_STATUS      = 4'h7;
    localparam logic [3:0] OP_CLEAR_ERR   = 4'hF;

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    logic [2:0]        state;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        opcode;
    logic              cmd_valid;
`ifdef CMD_FILL_EN
    logic [15:0]       fill_color;
    logic [15:0]       fill_count;
`endif

    assign opcode    = commandToGpu[15:12];
    assign cmd_valid = (commandToGpu != 16'd0);
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge commandClk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            addr        <= '0;
            dataFromGpu <= 16'd0;
            memAddr     <= '0;
            memWrData   <= 16'd0;
            memWrEn     <= 1'b0;
            memRdEn     <= 1'b0;
            errorFlag   <= 1'b0;
`ifdef CMD_FILL_EN
            fill_color  <= 16'd0;
            fill_count  <= 16'd0;
`endif
        end else begin
            // NOTE: non-blocking throughout, so every branch below reads pre-edge register values.
            // A command landing while a request is in flight is dropped (overrun).
            if (cmd_valid && busy)
                errorFlag <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        case (opcode)
                            OP_SET_ADDR_LO: addr[15:0] <= dataToGpu;
                            OP_SET_ADDR_HI: addr[ADDR_W-1:16] <= dataToGpu[ADDR_W-17:0];
                            OP_WRITE: begin
                                state     <= ST_WRITE;
                                memWrEn   <= 1'b1;
                                memAddr   <= addr;
                                memWrData <= dataToGpu;
                            end
                            OP_READ: begin
                                state   <= ST_READ_REQ;
                                memRdEn <= 1'b1;
                                memAddr <= addr;
                            end
                            OP_STATUS:    dataFromGpu <= {busy, errorFlag, 14'd0};
                            OP_CLEAR_ERR: errorFlag <= 1'b0;
`ifdef CMD_FILL_EN
                            OP_SET_FILL:  fill_color <= dataToGpu;
                            OP_FILL: begin
                                fill_count <= dataToGpu;
                                if (dataToGpu != 16'd0) begin
                                    state     <= ST_FILL;
                                    memWrEn   <= 1'b1;
                                    memAddr   <= addr;
                                    memWrData <= fill_color;
                                end
                            end
`endif
                            default: errorFlag <= 1'b1;
                        endcase
                    end
                end

                ST_WRITE: begin
                    if (memReady) begin
                        memWrEn <= 1'b0;
                        addr    <= addr + ADDR_ONE;
                        state   <= ST_IDLE;
                    end
                end

                ST_READ_REQ: begin
                    if (memReady) begin
                        memRdEn <= 1'b0;
                        addr    <= addr + ADDR_ONE;
                        state   <= ST_READ_WAIT;
                    end
                end

                ST_READ_WAIT: begin
                    if (memRdValid) begin
                        dataFromGpu <= memRdData;
                        state       <= ST_IDLE;
                    end
                end

`ifdef CMD_FILL_EN
                ST_FILL: begin
                    if (memReady) begin
                        addr       <= addr + ADDR_ONE;
                        fill_count <= fill_count - 16'd1;
                        if (fill_count == 16'd1) begin
                            memWrEn <= 1'b0;
                            state   <= ST_IDLE;
                        end else begin
                            memAddr <= addr + ADDR_ONE;
                        end
                    end
                end
`endif

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_command_decoder.sv
// Scoreboard bench for command_decoder: stimulus pushes expected memory requests,
// a negedge monitor pops and compares every accepted request.
`timescale 1ns/1ps

module tb_command_decoder;

    localparam int ADDR_W = 20;

    logic              commandClk = 1'b0;
    logic              reset = 1'b0;
    logic [15:0]       commandToGpu = 16'd0;
    logic [15:0]       dataToGpu = 16'd0;
    logic [15:0]       dataFromGpu;
    logic [ADDR_W-1:0] memAddr;
    logic [15:0]       memWrData;
    logic              memWrEn;
    logic              memRdEn;
    logic              memReady = 1'b0;
    logic [15:0]       memRdData = 16'd0;
    logic              memRdValid = 1'b0;
    logic              busy;
    logic              errorFlag;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [15:0]       data;
    } wr_t;

    wr_t               wr_q[$];
    logic [ADDR_W-1:0] rd_q[$];
    wr_t               exp_wr;
    logic [ADDR_W-1:0] exp_rd;

    command_decoder #(.ADDR_W(ADDR_W)) dut (
        .commandClk  (commandClk),
        .reset       (reset),
        .commandToGpu(commandToGpu),
        .dataToGpu   (dataToGpu),
        .dataFromGpu (dataFromGpu),
        .memAddr     (memAddr),
        .memWrData   (memWrData),
        .memWrEn     (memWrEn),
        .memRdEn     (memRdEn),
        .memReady    (memReady),
        .memRdData   (memRdData),
        .memRdValid  (memRdValid),
        .busy        (busy),
        .errorFlag   (errorFlag)
    );

    always #5 commandClk = ~commandClk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: inputs change #1 after posedge, so at negedge memReady/memXxEn show the coming accept.
    always @(negedge commandClk) begin
        if (!reset) begin
            if (memWrEn && memRdEn) begin
                miscompares++;
                $display("FAIL req_exclusive: memWrEn=1 and memRdEn=1 together at %0t", $time);
            end
            if (memWrEn && memReady) begin
                if (wr_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected none", memAddr, memWrData);
                end else begin
                    exp_wr = wr_q.pop_front();
                    check("wr_addr", 32'(memAddr), 32'(exp_wr.addr));
                    check("wr_data", 32'(memWrData), 32'(exp_wr.data));
                end
            end
            if (memRdEn && memReady) begin
                if (rd_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_read: addr 0x%0h, expected none", memAddr);
                end else begin
                    exp_rd = rd_q.pop_front();
                    check("rd_addr", 32'(memAddr), 32'(exp_rd));
                end
            end
        end
    end

    // One-cycle command pulse; returns #1 after the decode edge.
    task automatic send(input logic [3:0] op, input logic [15:0] data);
        @(posedge commandClk); #1;
        commandToGpu = {op, 12'h000};
        dataToGpu    = data;
        @(posedge commandClk); #1;
        commandToGpu = 16'd0;
        dataToGpu    = 16'd0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(posedge commandClk); #1;
            n++;
        end
        check("wait_idle", 32'(busy), 32'd0);
    endtask

    // Single write with memReady held high, used to probe the current address.
    task automatic probe_write(input logic [ADDR_W-1:0] exp_addr, input logic [15:0] data);
        wr_q.push_back('{addr: exp_addr, data: data});
        send(4'h3, data);
        memReady = 1'b1;
        wait_idle(10);
        memReady = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 reset = 1'b1;
        repeat (2) @(posedge commandClk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_error", 32'(errorFlag), 32'd0);
        check("rst_wr_en", 32'(memWrEn), 32'd0);
        check("rst_rd_en", 32'(memRdEn), 32'd0);
        check("rst_data_out", 32'(dataFromGpu), 32'd0);
        check("rst_mem_addr", 32'(memAddr), 32'd0);
        reset = 1'b0;

        // Write with memReady held low for three cycles.
        send(4'h1, 16'h1234);
        send(4'h2, 16'h0005);
        wr_q.push_back('{addr: 20'h51234, data: 16'hBEEF});
        send(4'h3, 16'hBEEF);
        check("wr_en_raised", 32'(memWrEn), 32'd1);
        check("busy_write", 32'(busy), 32'd1);
        repeat (3) @(posedge commandClk);
        #1 memReady = 1'b1;
        @(posedge commandClk); #1 memReady = 1'b0;
        check("wr_en_dropped", 32'(memWrEn), 32'd0);
        check("busy_after_write", 32'(busy), 32'd0);
        check("no_error_write", 32'(errorFlag), 32'd0);
        probe_write(20'h51235, 16'h0001);

        // Read at top of address space, data returned two cycles after accept.
        send(4'h1, 16'hFFFF);
        send(4'h2, 16'h000F);
        rd_q.push_back(20'hFFFFF);
        send(4'h4, 16'h0000);
        check("rd_en_raised", 32'(memRdEn), 32'd1);
        memReady = 1'b1;
        @(posedge commandClk); #1 memReady = 1'b0;
        check("rd_en_dropped", 32'(memRdEn), 32'd0);
        check("busy_read_wait", 32'(busy), 32'd1);
        @(posedge commandClk); #1;
        memRdValid = 1'b1;
        memRdData  = 16'hA5A5;
        @(posedge commandClk); #1;
        memRdValid = 1'b0;
        memRdData  = 16'h0000;
        check("read_data", 32'(dataFromGpu), 32'h0000A5A5);
        check("busy_after_read", 32'(busy), 32'd0);
        check("no_error_wrap", 32'(errorFlag), 32'd0);
        probe_write(20'h00000, 16'h2222);

        // Overrun: second write two cycles after the first while memReady is low.
        wr_q.push_back('{addr: 20'h00001, data: 16'h3333});
        send(4'h3, 16'h3333);
        send(4'h3, 16'h4444);
        check("overrun_error", 32'(errorFlag), 32'd1);
        check("overrun_keeps_data", 32'(memWrData), 32'h3333);
        memReady = 1'b1;
        wait_idle(10);
        memReady = 1'b0;
        send(4'h7, 16'h0000);
        check("status_err", 32'(dataFromGpu), 32'h00004000);
        send(4'hF, 16'h0000);
        check("clear_err", 32'(errorFlag), 32'd0);
        send(4'h7, 16'h0000);
        check("status_clean", 32'(dataFromGpu), 32'h00000000);

        // Illegal opcode only sets the error flag.
        send(4'h8, 16'h1111);
        check("illegal_error", 32'(errorFlag), 32'd1);
        check("illegal_busy", 32'(busy), 32'd0);
        send(4'hF, 16'h0000);
        probe_write(20'h00002, 16'h2323);

`ifdef CMD_FILL_EN
        send(4'h1, 16'h0100);
        send(4'h2, 16'h0000);
        send(4'h5, 16'h07E0);
        for (int i = 0; i < 4; i++)
            wr_q.push_back('{addr: 20'h00100 + 20'(i), data: 16'h07E0});
        send(4'h6, 16'd4);
        check("fill_busy", 32'(busy), 32'd1);
        memReady = 1'b1;
        wait_idle(20);
        memReady = 1'b0;
        probe_write(20'h00104, 16'h5555);
        send(4'h6, 16'd0);
        check("fill0_busy", 32'(busy), 32'd0);
        check("fill0_wr_en", 32'(memWrEn), 32'd0);
        check("fill0_error", 32'(errorFlag), 32'd0);
        probe_write(20'h00105, 16'h5656);
`else
        send(4'h6, 16'd3);
        check("fill_off_error", 32'(errorFlag), 32'd1);
        check("fill_off_busy", 32'(busy), 32'd0);
        check("fill_off_wr_en", 32'(memWrEn), 32'd0);
        send(4'hF, 16'h0000);
        probe_write(20'h00003, 16'h5555);
`endif

        // Reset in READ_WAIT, then a late memRdValid must be ignored.
        send(4'h1, 16'h0777);
        send(4'h2, 16'h0000);
        rd_q.push_back(20'h00777);
        send(4'h4, 16'h0000);
        memReady = 1'b1;
        @(posedge commandClk); #1 memReady = 1'b0;
        check("busy_before_rst", 32'(busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("midrst_rd_en", 32'(memRdEn), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_mem_addr", 32'(memAddr), 32'd0);
        check("midrst_data_out", 32'(dataFromGpu), 32'd0);
        @(posedge commandClk); #1 reset = 1'b0;
        memRdValid = 1'b1;
        memRdData  = 16'h1234;
        @(posedge commandClk); #1;
        memRdValid = 1'b0;
        memRdData  = 16'h0000;
        check("late_valid_ignored", 32'(dataFromGpu), 32'd0);
        check("late_valid_busy", 32'(busy), 32'd0);
        probe_write(20'h00000, 16'h6666);

        repeat (2) @(posedge commandClk);
        #1;
        check("wr_queue_drained", 32'(wr_q.size()), 32'd0);
        check("rd_queue_drained", 32'(rd_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
